// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: FSM states, RV32I major opcodes and alu_op class encodings shared by the control path
package rv_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_I   = 3'b001;
    localparam logic [2:0] ALU_LD  = 3'b010;
    localparam logic [2:0] ALU_ST  = 3'b011;
    localparam logic [2:0] ALU_BR  = 3'b100;
    localparam logic [2:0] ALU_JMP = 3'b101;

    // Wait counter must be able to hold the timeout value itself, never narrower than 4 bits
    function automatic int cnt_width(input int timeout);
        return ($clog2(timeout + 1) > 4) ? $clog2(timeout + 1) : 4;
    endfunction

endpackage

// File: rtl/rv_opcode_decode.sv
// rv_opcode_decode: combinational opcode classifier feeding the multicycle control FSM
module rv_opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] alu_op,
    output logic       legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump
);

    always_comb begin
        alu_op    = ALU_R;
        legal     = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        case (opcode)
            OP_R:             alu_op = ALU_R;
            OP_I:             alu_op = ALU_I;
            OP_LUI, OP_AUIPC: alu_op = ALU_LD;
            OP_LOAD: begin
                alu_op  = ALU_LD;
                is_load = 1'b1;
            end
            OP_STORE: begin
                alu_op   = ALU_ST;
                is_store = 1'b1;
            end
            OP_BRANCH: begin
                alu_op    = ALU_BR;
                is_branch = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                alu_op  = ALU_JMP;
                is_jump = 1'b1;
            end
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RV32I core,
// with memory-wait timeout and a sticky trap state left only through reset.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_write,
    output logic [2:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        retire,
    output logic        trap
);

    localparam int CW = cnt_width(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

    state_t        state_q, state_d;
    logic [6:0]    opc_q, opc_d;
    logic [2:0]    alu_q, alu_d, dec_alu;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          legal, is_load, is_store, is_branch, is_jump;
    logic          instr_unused;

    assign instr_unused = ^instr[31:7];
    assign alu_op = alu_q;

    rv_opcode_decode u_dec (
        .opcode   (opc_q),
        .alu_op   (dec_alu),
        .legal    (legal),
        .is_load  (is_load),
        .is_store (is_store),
        .is_branch(is_branch),
        .is_jump  (is_jump)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opc_q   <= '0;
            alu_q   <= ALU_R;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            alu_q   <= alu_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        cnt_d     = cnt_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        retire    = 1'b0;
        trap      = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                opc_d    = imem_ready ? instr[6:0] : opc_q;
                cnt_d    = cnt_q + CW'(1);
                // ready on the final counted cycle still wins over the timeout
                state_d  = imem_ready ? DECODE : (cnt_q == CNT_MAX) ? TRAP : FETCH;
            end
            DECODE: state_d = legal ? EXEC : TRAP;
            EXEC: begin
                pc_write = is_branch;
                pc_sel   = is_branch && branch_taken;
                retire   = is_branch;
                state_d  = (is_load || is_store) ? MEM : is_branch ? FETCH : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_write = dmem_ready && is_store;
                retire   = dmem_ready && is_store;
                cnt_d    = cnt_q + CW'(1);
                state_d  = dmem_ready ? (is_load ? WB : FETCH) : (cnt_q == CNT_MAX) ? TRAP : MEM;
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_sel    = is_jump;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q && (state_d == FETCH || state_d == MEM))
            cnt_d = '0;
        // alu_op class is captured leaving DECODE and only visible while the instruction is in flight
        alu_d = (state_d inside {EXEC, MEM, WB}) ? ((state_q == DECODE) ? dec_alu : alu_q) : ALU_R;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction/memory-latency stimulus against a per-instruction
// outcome model; a negedge monitor pops expected retire/trap events from a scoreboard queue.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    typedef struct packed {
        bit       tr;
        bit [2:0] alu;
        bit       rw;
        bit       ps;
        bit       we;
        int       lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
    logic        imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, pc_sel, retire, trap;
    logic [2:0]  alu_op;

    int          checks = 0, passed = 0, cyc = 0;
    int          mon_start = 0, pick = 0;
    bit          mon_in_f = 1'b0, mon_tr = 1'b0;
    exp_t        mon_e;
    logic [31:0] rnd;
    exp_t        exp_q[$];
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .branch_taken(branch_taken),
        .imem_req    (imem_req),
        .ir_write    (ir_write),
        .alu_op      (alu_op),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .reg_write   (reg_write),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .retire      (retire),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one instruction: retire or trap, and cycles from first FETCH cycle to that event
    function automatic exp_t model(input logic [6:0] op, input bit bt, input int di, input int dd);
        exp_t e = '0;
        bit ld = (op == 7'h03);
        bit st = (op == 7'h23);
        bit br = (op == 7'h63);
        bit jp = (op == 7'h6F) || (op == 7'h67);
        bit lg = ld || st || br || jp || (op inside {7'h33, 7'h13, 7'h37, 7'h17});
        e.we  = st;
        e.rw  = !(st || br);
        e.ps  = jp || (br && bt);
        e.alu = br ? 3'd4 : jp ? 3'd5 : st ? 3'd3 : (op == 7'h33) ? 3'd0 : (op == 7'h13) ? 3'd1 : 3'd2;
        if (di > TO) begin
            e.tr  = 1'b1;
            e.lat = TO + 2;
        end else if (!lg) begin
            e.tr  = 1'b1;
            e.lat = di + 3;
        end else if ((ld || st) && dd > TO) begin
            e.tr  = 1'b1;
            e.lat = di + TO + 5;
        end else begin
            e.lat = (di + 1) + 2 + ((ld || st) ? dd + 1 : 0) + (e.rw ? 1 : 0);
        end
        return e;
    endfunction

    function automatic int pick_delay();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 1)) : int'($urandom_range(0, 3));
    endfunction

    task automatic wait_trap();
        for (int n = 0; n < 5 && !trap; n++) step();
        chk("trap_set", 32'(trap), 1);
        for (int k = 0; k < 20; k++) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            step();
            chk("trap_sticky", 32'(trap), 1);
            chk("trap_quiet", 32'({imem_req, ir_write, dmem_req, pc_write, reg_write, retire, alu_op}), 0);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int di, input int dd, input bit bt);
        exp_t e = model(ins[6:0], bt, di, dd);
        bit ls = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
        for (int n = 0; n < 20 && !imem_req; n++) step();
        chk("fetch_start", 32'(imem_req), 1);
        if (!imem_req) return;
        exp_q.push_back(e);
        for (int k = 0; k < ((di > TO) ? TO + 1 : di); k++) begin
            imem_ready = 1'b0;
            dmem_ready = 1'($urandom_range(0, 1));
            step();
        end
        dmem_ready = 1'b0;
        if (di > TO) begin
            wait_trap();
            return;
        end
        imem_ready   = 1'b1;
        instr        = ins;
        branch_taken = bt;
        step();
        imem_ready = 1'b0;
        instr      = $urandom;
        if (e.tr && !ls) begin
            wait_trap();
            return;
        end
        if (!ls) return;
        for (int n = 0; n < 5 && !dmem_req; n++) step();
        chk("mem_start", 32'(dmem_req), 1);
        for (int k = 0; k < ((dd > TO) ? TO + 1 : dd); k++) begin
            dmem_ready = 1'b0;
            imem_ready = 1'($urandom_range(0, 1));
            step();
        end
        imem_ready = 1'b0;
        if (dd > TO) begin
            wait_trap();
            return;
        end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_in_f = 1'b0;
                mon_tr   = 1'b0;
            end else begin
                if (imem_req && !mon_in_f) mon_start = cyc;
                mon_in_f = imem_req;
                chk("wr_without_retire", 32'((pc_write || reg_write) && !retire), 0);
                if (imem_req) chk("alu_op_fetch", 32'(alu_op), 0);
                if (dmem_req && exp_q.size() > 0) chk("dmem_we", 32'(dmem_we), 32'(exp_q[0].we));
                if (retire || (trap && !mon_tr)) begin
                    mon_tr = trap;
                    chk("event_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        chk("is_trap", 32'(trap), 32'(mon_e.tr));
                        chk("latency", cyc - mon_start + 1, mon_e.lat);
                        if (retire) begin
                            chk("alu_op", 32'(alu_op), 32'(mon_e.alu));
                            chk("reg_write", 32'(reg_write), 32'(mon_e.rw));
                            chk("pc_sel", 32'(pc_sel), 32'(mon_e.ps));
                            chk("pc_write", 32'(pc_write), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) step();
        chk("rst_outputs", 32'({imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, pc_sel, retire, trap}), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        rst = 1'b0;
        #1 chk("idle_outputs", 32'({imem_req, ir_write, dmem_req, reg_write, pc_write, retire, trap, alu_op}), 0);
        do_instr(32'h002081B3, 0, 0, 1'b0);
        do_instr(32'h0000A103, 0, 3, 1'b0);
        do_instr(32'h00208463, 0, 0, 1'b1);
        do_instr(32'h00208463, 0, 0, 1'b0);
        do_instr(32'h0000A023, 0, TO, 1'b0);
        do_instr(32'h0000A023, 0, TO + 1, 1'b0);
        do_instr(32'hFFFFFFFF, 1, 0, 1'b0);
        do_instr(32'h0000006F, TO, 0, 1'b0);
        do_instr(32'h002081B3, TO + 1, 0, 1'b0);
        do_instr(32'h000080E7, 2, 0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            rnd      = $urandom;
            pick     = $urandom_range(0, 19);
            rnd[6:0] = (pick < 18) ? ops[pick % 9] : 7'h7F;
            do_instr(rnd, pick_delay(), pick_delay(), 1'($urandom_range(0, 1)));
        end
        drain();
        for (int n = 0; n < 20 && !imem_req; n++) step();
        imem_ready = 1'b1;
        instr      = 32'h0000A023;
        step();
        imem_ready = 1'b0;
        for (int n = 0; n < 5 && !dmem_req; n++) step();
        chk("abort_in_mem", 32'(dmem_req), 1);
        step();
        #2 rst = 1'b1;
        #1 chk("abort_req_drop", 32'({dmem_req, dmem_we, retire, pc_write, reg_write}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("abort_idle", 32'(imem_req), 0);
        step();
        chk("abort_refetch", 32'(imem_req), 1);
        do_instr(32'h00C000EF, 0, 0, 1'b0);
        do_instr(32'h0000A103, 1, 2, 1'b0);
        drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
